// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller:
//            FSM state encoding, default watchdog limit, control bundle and
//            a register-match helper used by the load-use detector.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Default number of data-memory wait cycles tolerated before the sticky error
  localparam int DEF_TIMEOUT = 255;

  // Controller state encoding; values are visible on state_o
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // Stall/bubble controls for the four pipeline registers
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic f_bubble;
    logic d_bubble;
    logic m_bubble;
  } ctrl_t;

  // True when a source operand is actually read and names the given register
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs,
                                   input logic [4:0] dst);
    return use_src && (rs == dst);
  endfunction

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous increment and
//            asynchronous active-low clear; holds at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // Count up on request, stopping once every bit is set
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Five-stage pipeline hazard/stall controller. Resolves data-memory
//            waits (with watchdog), branch mispredict flushes and load-use
//            hazards in strict priority, and keeps saturating stall and flush
//            performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       D_rs1_i,
  input  logic [4:0]       D_rs2_i,
  input  logic             D_use_rs1_i,
  input  logic             D_use_rs2_i,
  input  logic             DD_need_dstE_i,
  input  logic [4:0]       DD_dstE_i,
  input  logic             DD_is_load_i,
  input  logic             E_mispredict_i,
  input  logic             M_req_i,
  input  logic             M_ack_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             F_bubble_o,
  output logic             D_bubble_o,
  output logic             M_bubble_o,
  output logic             mem_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Wide enough to hold TIMEOUT itself
  localparam int                WAIT_W      = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_hold;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctrl;

  // Memory stall: live request without ack, or permanently once in error
  assign mem_hold = ((state != ST_ERR) && M_req_i && !M_ack_i) || (state == ST_ERR);

  // Load result needed by decode next cycle; x0 is never a real dependency
  assign load_use = DD_is_load_i && DD_need_dstE_i && (DD_dstE_i != 5'd0) &&
                    (src_hit(D_use_rs1_i, D_rs1_i, DD_dstE_i) ||
                     src_hit(D_use_rs2_i, D_rs2_i, DD_dstE_i));

  // State and watchdog registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state logic; an ack always beats the watchdog in the same cycle
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      ST_RUN: begin
        if (M_req_i && !M_ack_i) begin
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (M_ack_i) begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_nxt = ST_ERR;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Pipeline controls in priority order; all forced low while reset is held
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      if (mem_hold) begin
        // Execute is frozen, so a mispredict or load-use re-presents later
        ctrl.f_stall  = 1'b1;
        ctrl.d_stall  = 1'b1;
        ctrl.e_stall  = 1'b1;
        ctrl.m_bubble = 1'b1;
      end else if (E_mispredict_i) begin
        ctrl.f_bubble = 1'b1;
        ctrl.d_bubble = 1'b1;
      end else if (load_use) begin
        ctrl.f_stall  = 1'b1;
        ctrl.d_bubble = 1'b1;
      end
    end
  end

  assign F_stall_o  = ctrl.f_stall;
  assign D_stall_o  = ctrl.d_stall;
  assign E_stall_o  = ctrl.e_stall;
  assign F_bubble_o = ctrl.f_bubble;
  assign D_bubble_o = ctrl.d_bubble;
  assign M_bubble_o = ctrl.m_bubble;
  assign mem_err_o  = (state == ST_ERR);
  assign state_o    = state;

  // Count the controls actually applied, after priority resolution
  assign stall_inc = ctrl.f_stall;
  assign flush_inc = ctrl.f_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule : hazard_ctrl
`default_nettype wire
